// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants and types for the on-screen text path
package text_pkg;

    localparam int GLYPH_W    = 50;
    localparam int NUM_GLYPHS = 26;

    localparam logic [4:0] BLANK_LETTER = 5'd31;

    localparam logic [4:0] LTR_E = 5'd4;
    localparam logic [4:0] LTR_I = 5'd8;
    localparam logic [4:0] LTR_M = 5'd12;
    localparam logic [4:0] LTR_P = 5'd15;
    localparam logic [4:0] LTR_S = 5'd18;
    localparam logic [4:0] LTR_T = 5'd19;
    localparam logic [4:0] LTR_U = 5'd20;

    typedef logic [7:0] rgb332_t;

endpackage

// File: rtl/glyph_rom.sv
// rtl/glyph_rom.sv - 65000 x 1 glyph bitmap ROM, 16-bit address, 1-cycle synchronous read
module glyph_rom (
    input  logic        clk,
    input  logic [15:0] addr,
    output logic        rd_data
);

    localparam logic [15:0] DEPTH = 16'd65000;

    // Bitmap content is a fixed address pattern; addresses past the last glyph read as clear.
    always_ff @(posedge clk) begin
        if (addr < DEPTH)
            rd_data <= ^(addr & 16'h8109);
        else
            rd_data <= 1'b0;
    end

endmodule

// File: rtl/glyph_pixel_renderer.sv
// rtl/glyph_pixel_renderer.sv - 3-stage (letter, pixel) to RGB332 renderer; optional blink via BLINK_EN
module glyph_pixel_renderer
    import text_pkg::*;
#(
    parameter int      GLYPH_W      = text_pkg::GLYPH_W,
    parameter int      NUM_GLYPHS   = text_pkg::NUM_GLYPHS,
    parameter rgb332_t FG_COLOR     = 8'hFF,
    parameter rgb332_t BG_COLOR     = 8'h00,
    parameter int      BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    input  logic [4:0]  letter,
    input  logic [12:0] pixel,
    input  logic        frame_tick,
    output logic        out_valid,
    output rgb332_t     color,
    output logic [8:0]  out_row,
    output logic [9:0]  out_col
);

    localparam logic [15:0] GLYPH_SIZE = 16'(GLYPH_W * GLYPH_W);
    localparam logic [12:0] PIX_LIMIT  = 13'(GLYPH_W * GLYPH_W);
    localparam logic [4:0]  LTR_LIMIT  = 5'(NUM_GLYPHS);

    logic        s1_valid, s1_draw;
    logic [15:0] s1_addr;
    logic [8:0]  s1_row;
    logic [9:0]  s1_col;

    logic        s2_valid, s2_draw;
    logic [8:0]  s2_row;
    logic [9:0]  s2_col;

    logic        rom_bit;
    logic        draw_next;
    logic        visible;

    assign draw_next = (letter < LTR_LIMIT) && (pixel < PIX_LIMIT);

`ifdef BLINK_EN
    logic [5:0] blink_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= 6'd0;
            visible   <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt == 6'(BLINK_FRAMES - 1)) begin
                blink_cnt <= 6'd0;
                visible   <= ~visible;
            end else begin
                blink_cnt <= blink_cnt + 6'd1;
            end
        end
    end
`else
    logic unused_frame_tick;
    assign unused_frame_tick = frame_tick;
    assign visible = 1'b1;
`endif

    // Blank letters and out-of-glyph pixels park the address at 0 so the ROM stays in range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_draw  <= 1'b0;
            s1_addr  <= 16'd0;
            s1_row   <= 9'd0;
            s1_col   <= 10'd0;
        end else begin
            s1_valid <= in_valid;
            s1_draw  <= draw_next;
            s1_addr  <= draw_next ? (16'(letter) * GLYPH_SIZE + 16'(pixel)) : 16'd0;
            s1_row   <= row;
            s1_col   <= col;
        end
    end

    glyph_rom u_glyph_rom (
        .clk     (clk),
        .addr    (s1_addr),
        .rd_data (rom_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_draw  <= 1'b0;
            s2_row   <= 9'd0;
            s2_col   <= 10'd0;
        end else begin
            s2_valid <= s1_valid;
            s2_draw  <= s1_draw;
            s2_row   <= s1_row;
            s2_col   <= s1_col;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            color     <= BG_COLOR;
            out_row   <= 9'd0;
            out_col   <= 10'd0;
        end else begin
            out_valid <= s2_valid;
            color     <= (s2_draw && rom_bit && visible) ? FG_COLOR : BG_COLOR;
            out_row   <= s2_row;
            out_col   <= s2_col;
        end
    end

endmodule

// File: tb/tb_glyph_pixel_renderer.sv
// tb/tb_glyph_pixel_renderer.sv - directed self-checking bench for glyph_pixel_renderer
module tb_glyph_pixel_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [8:0]  row;
    logic [9:0]  col;
    logic [4:0]  letter;
    logic [12:0] pixel;
    logic        frame_tick;
    logic        out_valid;
    logic [7:0]  color;
    logic [8:0]  out_row;
    logic [9:0]  out_col;

    int passed = 0;
    int total  = 0;

    localparam int MAXV = 2600;
    logic        v_valid  [MAXV];
    logic [8:0]  v_row    [MAXV];
    logic [9:0]  v_col    [MAXV];
    logic [4:0]  v_letter [MAXV];
    logic [12:0] v_pixel  [MAXV];
    logic        o_valid  [MAXV];
    logic [7:0]  o_color  [MAXV];
    logic [8:0]  o_row    [MAXV];
    logic [9:0]  o_col    [MAXV];
    logic        pre_valid [2];

    always #5 clk = ~clk;

`ifdef BLINK_EN
    glyph_pixel_renderer #(.BLINK_FRAMES(2)) dut (
`else
    glyph_pixel_renderer dut (
`endif
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .row        (row),
        .col        (col),
        .letter     (letter),
        .pixel      (pixel),
        .frame_tick (frame_tick),
        .out_valid  (out_valid),
        .color      (color),
        .out_row    (out_row),
        .out_col    (out_col)
    );

    // Expected color: ROM bitmap is the parity of address bits 15, 8, 3 and 0.
    function automatic logic [7:0] exp_color(input logic [4:0] l, input logic [12:0] p);
        logic [15:0] a;
        if (l >= 5'd26 || p >= 13'd2500)
            return 8'h00;
        a = 16'(int'(l) * 2500 + int'(p));
        return (a[15] ^ a[8] ^ a[3] ^ a[0]) ? 8'hFF : 8'h00;
    endfunction

    task automatic idle(input int n);
        in_valid   = 1'b0;
        frame_tick = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic play(input int n, input int tick_period);
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                in_valid = v_valid[i];
                row      = v_row[i];
                col      = v_col[i];
                letter   = v_letter[i];
                pixel    = v_pixel[i];
            end else begin
                in_valid = 1'b0;
            end
            frame_tick = (tick_period > 0) && (i % tick_period == 0);
            @(posedge clk);
            #1;
            if (i >= 2) begin
                o_valid[i-2] = out_valid;
                o_color[i-2] = color;
                o_row[i-2]   = out_row;
                o_col[i-2]   = out_col;
            end else begin
                pre_valid[i] = out_valid;
            end
        end
        frame_tick = 1'b0;
        @(posedge clk);
        #1;
        o_valid[n] = out_valid;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(3);
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid);
        else passed++;
        total++;
        if (color !== 8'h00) $display("FAIL reset_color got %h want 00", color);
        else passed++;
        total++;
        if (out_row !== 9'd0) $display("FAIL reset_row got %0d want 0", out_row);
        else passed++;
        total++;
        if (out_col !== 10'd0) $display("FAIL reset_col got %0d want 0", out_col);
        else passed++;
        reset = 1'b0;
        idle(3);
    endtask

    task automatic test_stream_t;
        for (int i = 0; i < 2500; i++) begin
            v_valid[i]  = 1'b1;
            v_letter[i] = 5'd19;
            v_pixel[i]  = 13'(i);
            v_row[i]    = 9'(i);
            v_col[i]    = 10'(i * 3);
        end
        play(2500, 0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (pre_valid[i] !== 1'b0) $display("FAIL stream_latency cycle %0d out_valid %b want 0", i, pre_valid[i]);
            else passed++;
        end
        total++;
        if (o_color[0] !== 8'hFF) $display("FAIL stream_first_pixel got %h want FF", o_color[0]);
        else passed++;
        for (int i = 0; i < 2500; i++) begin
            total++;
            if (o_valid[i] !== 1'b1 || o_color[i] !== exp_color(5'd19, 13'(i)) ||
                o_row[i] !== v_row[i] || o_col[i] !== v_col[i])
                $display("FAIL stream_T pixel %0d got v=%b c=%h r=%0d k=%0d want v=1 c=%h r=%0d k=%0d",
                         i, o_valid[i], o_color[i], o_row[i], o_col[i],
                         exp_color(5'd19, 13'(i)), v_row[i], v_col[i]);
            else passed++;
        end
        total++;
        if (o_valid[2500] !== 1'b0) $display("FAIL stream_tail out_valid %b want 0", o_valid[2500]);
        else passed++;
        idle(2);
    endtask

    task automatic test_boundaries;
        logic [4:0]  bl [8];
        logic [12:0] bp [8];
        logic [7:0]  be [8];
        bl = '{5'd31, 5'd31, 5'd26, 5'd0,    5'd25,   5'd0,    5'd19, 5'd13};
        bp = '{13'd0, 13'd2499, 13'd100, 13'd2500, 13'd2499, 13'd2499, 13'd0, 13'd1234};
        for (int i = 0; i < 8; i++) begin
            v_valid[i]  = 1'b1;
            v_letter[i] = bl[i];
            v_pixel[i]  = bp[i];
            v_row[i]    = 9'(100 + i);
            v_col[i]    = 10'(600 + i);
            be[i]       = exp_color(bl[i], bp[i]);
        end
        // addr 64999 = 16'hFDE7 -> parity 1 -> FG; letter 0 pixel 2499 addr 16'h09C3 -> parity 0
        be[4] = 8'hFF;
        be[5] = 8'h00;
        play(8, 0);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (o_valid[i] !== 1'b1 || o_color[i] !== be[i])
                $display("FAIL boundary l=%0d p=%0d got v=%b c=%h want v=1 c=%h",
                         bl[i], bp[i], o_valid[i], o_color[i], be[i]);
            else passed++;
        end
        idle(2);
    endtask

    task automatic test_alternate;
        for (int i = 0; i < 12; i++) begin
            v_valid[i]  = (i % 2 == 0);
            v_letter[i] = 5'd25;
            v_pixel[i]  = 13'd2499;
            v_row[i]    = 9'(i);
            v_col[i]    = 10'(i);
        end
        play(12, 0);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (o_valid[i] !== v_valid[i] || (v_valid[i] && o_color[i] !== 8'hFF))
                $display("FAIL alternate cycle %0d got v=%b c=%h want v=%b", i, o_valid[i], o_color[i], v_valid[i]);
            else passed++;
        end
        idle(2);
    endtask

    task automatic test_reset_midstream;
        logic seen;
        in_valid = 1'b1;
        letter   = 5'd25;
        pixel    = 13'd2499;
        row      = 9'd7;
        col      = 10'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || color !== 8'h00)
            $display("FAIL midreset_async got v=%b c=%h want v=0 c=00", out_valid, color);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (color !== 8'h00) $display("FAIL midreset_hold color %h want 00", color);
        else passed++;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL midreset_flush out_valid rose got 1 want 0");
        else passed++;
        v_valid[0] = 1'b1; v_letter[0] = 5'd25; v_pixel[0] = 13'd2499; v_row[0] = 9'd3; v_col[0] = 10'd4;
        play(1, 0);
        total++;
        if (pre_valid[0] !== 1'b0 || pre_valid[1] !== 1'b0 || o_valid[0] !== 1'b1 ||
            o_color[0] !== 8'hFF || o_valid[1] !== 1'b0)
            $display("FAIL midreset_first got %b%b%b%b c=%h want 0010 c=FF",
                     pre_valid[0], pre_valid[1], o_valid[0], o_valid[1], o_color[0]);
        else passed++;
        idle(2);
    endtask

`ifndef BLINK_EN
    task automatic test_frame_tick_ignored;
        logic [7:0] ref_c [10];
        for (int i = 0; i < 10; i++) begin
            v_valid[i]  = 1'b1;
            v_letter[i] = 5'(i * 3 % 26);
            v_pixel[i]  = 13'(i * 251);
            v_row[i]    = 9'(i);
            v_col[i]    = 10'(i);
        end
        play(10, 0);
        for (int i = 0; i < 10; i++) ref_c[i] = o_color[i];
        play(10, 3);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (o_color[i] !== ref_c[i] || o_color[i] !== exp_color(v_letter[i], v_pixel[i]))
                $display("FAIL frame_tick_ignored %0d got %h want %h", i, o_color[i], ref_c[i]);
            else passed++;
        end
        idle(2);
    endtask
`else
    task automatic test_blink;
        logic vis;
        logic vis_before;
        int   cnt;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        vis = 1'b1;
        cnt = 0;
        in_valid = 1'b1;
        letter   = 5'd25;
        pixel    = 13'd2499;
        for (int i = 0; i < 90; i++) begin
            frame_tick = (i % 10 == 5);
            @(posedge clk);
            #1;
            vis_before = vis;
            if (frame_tick) begin
                if (cnt == 1) begin cnt = 0; vis = ~vis; end
                else cnt++;
            end
            if (i >= 3) begin
                total++;
                if (color !== (vis_before ? 8'hFF : 8'h00))
                    $display("FAIL blink cycle %0d got %h want %h", i, color, vis_before ? 8'hFF : 8'h00);
                else passed++;
            end
        end
        idle(3);
    endtask
`endif

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        row        = '0;
        col        = '0;
        letter     = '0;
        pixel      = '0;
        frame_tick = 1'b0;
        test_reset;
        test_stream_t;
        test_boundaries;
        test_alternate;
        test_reset_midstream;
`ifndef BLINK_EN
        test_frame_tick_ignored;
`else
        test_blink;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
